// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester handshakes and RAM pins shared by mem_arbiter and its neighbours.
interface mem_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_ack;
  logic                  if_rvalid;
  logic [WIDTH-1:0]      if_rdata;
  logic                  d_req;
  logic                  d_we;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [WIDTH-1:0]      d_wdata;
  logic                  d_ack;
  logic                  d_rvalid;
  logic [WIDTH-1:0]      d_rdata;
  logic                  busy;
  logic                  ram_write;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [WIDTH-1:0]      ram_inData;
  logic [WIDTH-1:0]      ram_outData;
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, ram_outData,
    output if_ack, if_rvalid, if_rdata, d_ack, d_rvalid, d_rdata, busy,
           ram_write, ram_addr, ram_inData
  );
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, ram_outData,
    input  if_ack, if_rvalid, if_rdata, d_ack, d_rvalid, d_rdata, busy,
           ram_write, ram_addr, ram_inData
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin IF/D sharing of a single-port RAM with a registered access stage.
// MEM_ARB_INIT_CLEAR_EN adds a post-reset zero-fill sweep of the whole RAM.
module mem_arbiter #(
  parameter int WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input logic         clk,
  input logic         reset,
  mem_arbiter_if.slave bus
);
  logic                  busy, gnt_if, gnt_d, last_d, pend_if, pend_d;
  logic [ADDR_WIDTH-1:0] sweep_addr;
`ifdef MEM_ARB_INIT_CLEAR_EN
  typedef enum logic {INIT, RUN} state_t;
  state_t                state, state_nx;
  logic [ADDR_WIDTH-1:0] cnt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= busy ? cnt + ADDR_WIDTH'(1) : '0;
    end
  always_comb state_nx = (state == INIT && &cnt) ? RUN : state;
  assign busy       = state == INIT;
  assign sweep_addr = cnt;
`else
  assign busy       = 1'b0;
  assign sweep_addr = '0;
`endif
  // on a tie, last_d=1 means D was served last so IF wins
  assign gnt_if     = !busy && bus.if_req && (!bus.d_req || last_d);
  assign gnt_d      = !busy && bus.d_req && (!bus.if_req || !last_d);
  assign bus.if_ack = gnt_if;
  assign bus.d_ack  = gnt_d;
  assign bus.busy   = busy;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      last_d         <= 1'b1;
      pend_if        <= 1'b0;
      pend_d         <= 1'b0;
      bus.if_rvalid  <= 1'b0;
      bus.d_rvalid   <= 1'b0;
      bus.if_rdata   <= '0;
      bus.d_rdata    <= '0;
      bus.ram_write  <= 1'b0;
      bus.ram_addr   <= '0;
      bus.ram_inData <= '0;
    end else begin
      pend_if       <= gnt_if;
      pend_d        <= gnt_d && !bus.d_we;
      bus.if_rvalid <= pend_if;
      bus.d_rvalid  <= pend_d;
      if (pend_if) bus.if_rdata <= bus.ram_outData;
      if (pend_d) bus.d_rdata <= bus.ram_outData;
      if (gnt_if || gnt_d) last_d <= gnt_d;
      if (busy) begin
        bus.ram_write  <= 1'b1;
        bus.ram_addr   <= sweep_addr;
        bus.ram_inData <= '0;
      end else if (gnt_if || gnt_d) begin
        bus.ram_write <= gnt_d && bus.d_we;
        bus.ram_addr  <= gnt_d ? bus.d_addr : bus.if_addr;
        if (gnt_d) bus.ram_inData <= bus.d_wdata;
      end else begin
        bus.ram_write <= 1'b0;
      end
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences and shares the single-port data/instruction RAM between two requesters: instruction fetch (IF) and data load/store (D).
- Owns the RAM write/address/data pins through a registered access stage and returns registered read data per requester.
- Optionally performs a post-reset zero-fill sweep of the whole RAM. When this block is present, the RAM's own reset input is tied low at top level.
- Sits between the multicycle controller/datapath and the RAM instance.

Parameters:
- WIDTH, 32, data word width.
- ADDR_WIDTH, 10, RAM address width; depth = 2^ADDR_WIDTH.

Ports:
- clk  input  1  single clock; all flops on posedge.
- reset  input  1  asynchronous active-low reset; reset is active when this port is 0.
- if_req  input  1  IF read request; held with stable if_addr until if_ack.
- if_addr  input  ADDR_WIDTH  IF read address.
- if_ack  output  1  combinational; request accepted on this clock edge.
- if_rvalid  output  1  one-cycle pulse; if_rdata valid.
- if_rdata  output  WIDTH  IF read data; holds until the next IF read.
- d_req  input  1  D request; held with stable d_we/d_addr/d_wdata until d_ack.
- d_we  input  1  1 = write, 0 = read.
- d_addr  input  ADDR_WIDTH  D address.
- d_wdata  input  WIDTH  D write data.
- d_ack  output  1  combinational accept.
- d_rvalid  output  1  one-cycle pulse for D reads only.
- d_rdata  output  WIDTH  D read data; holds until the next D read.
- busy  output  1  high during the init sweep.
- ram_write  output  1  registered RAM write enable.
- ram_addr  output  ADDR_WIDTH  registered RAM address.
- ram_inData  output  WIDTH  registered RAM write data.
- ram_outData  input  WIDTH  RAM combinational read data.

Behaviour:
- Reset values:
  - Outputs: ram_write=0, ram_addr=0, ram_inData=0, if_rdata=0, d_rdata=0, if_rvalid=0, d_rvalid=0.
  - Internal state: last-grant pointer = D, so IF wins the first tie; state = INIT if the feature is enabled, otherwise RUN.
- States:
  - INIT: sweep counter cnt from 0 to 2^ADDR_WIDTH-1. Each cycle loads ram_write=1, ram_addr=cnt, ram_inData=0. After cnt reaches the max, the next state is RUN.
  - busy=1 in INIT. No acks are issued in INIT; requests simply wait.
  - RUN: arbitration runs every cycle.
- Arbitration (RUN):
  - Only one requesting: that requester is acked.
  - Both requesting: round-robin; ack the requester not acked most recently.
  - The pointer updates only on an ack.
- Pipeline (one access per cycle; back-to-back accepts allowed):
  - Cycle N: ack high; the winner's addr/we/wdata are latched into ram_addr/ram_write/ram_inData. IF always latches we=0.
  - Cycle N+1: RAM access. If no accept occurred in N, ram_write=0 and ram_addr holds its value. For a read, ram_outData is captured into the owner's rdata at the end of N+1.
  - Cycle N+2: owner's rvalid=1 for exactly one cycle. Writes produce no rvalid.
- Read-after-write:
  - A D write accepted at N followed by a read of the same address accepted at N+1 returns the new data; the RAM is written at the end of N+1 and read in N+2.
- Address width: no wrap or overflow handling; addresses are used as-is.
- Reset asserted mid-operation:
  - All flops clear immediately and asynchronously; ram_write=0 at once.
  - In-flight accesses are discarded with no rvalid.
  - The sweep restarts from address 0 after release.
- Requesters must not drop req before ack; behaviour is undefined if they do.

Optional Feature:
- Macro: MEM_ARB_INIT_CLEAR_EN.
- Defined: INIT zero-fill sweep as above. Lasts 2^ADDR_WIDTH cycles after reset release; busy is high throughout.
- Not defined: no INIT state, no counter, busy tied 0. The arbiter is in RUN from the first clock after release; RAM contents after reset are unspecified.

Test Plan:
- Feature on, ADDR_WIDTH=4, reset released at cycle 0:
  - busy=1 for 16 cycles; ram_write=1 with ram_addr 0..15 and ram_inData 0.
  - if_req held throughout gets no ack until busy=0, then acks on the first RUN cycle.
- D write 0xdeadbeef to 0x12, then IF read of 0x12:
  - d_ack at N; ram_write=1 with ram_addr=0x12 in N+1.
  - IF accepted N+1, if_rvalid at N+3 with if_rdata=0xdeadbeef.
- Both requests held for 6 cycles after reset:
  - Acks go IF, D, IF, D, IF, D; one RAM access per cycle.
  - rvalid pulses follow each ack by 2 cycles.
- D write 0x0000beef to 0x12 at N, D read of 0x12 at N+1:
  - d_rvalid at N+3 with d_rdata=0x0000beef.
  - Only one d_rvalid pulse (writes give none).
- reset=0 asserted in the access cycle of a read:
  - ram_write and rvalid are 0 immediately; no rvalid after release.
  - With the feature on, the sweep restarts at address 0.
- Feature off: busy stays 0; a request in the first post-reset cycle is acked that cycle.
